ccsds_derandomizer: RTL

//  Downstream stage of the frame-sync detector. Consumes the 8-bit AXI-Stream codeword stream (tlast on final byte)
//  and XORs each byte with the CCSDS pseudo-random sequence, restarted at every codeword start.

---
 rtl/ccsds_derandomizer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ccsds_derandomizer.sv
// rtl/ccsds_derandomizer.sv - CCSDS PN derandomizer with codeword length check and 2-entry output buffer.
// Optional codeword/error statistics counters enabled by defining DERAND_STATS_EN.
module ccsds_derandomizer #(
    parameter int          CODEWORD_LEN = 255,
    parameter logic [7:0]  PN_SEED      = 8'hFF
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    input  logic        derand_en,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t      state, state_next;
    logic [7:0]  byte_cnt, byte_cnt_next;
    logic [7:0]  lfsr, lfsr_next;
    logic        en_lat, en_lat_next;
    logic [8:0]  cnt_inc;
    logic        at_len;
    logic        en_cur;
    logic        accept;
    logic        out_pop;
    logic [7:0]  word_data;
    logic        word_last;
    logic        word_user;

    logic [7:0]  skid_data;
    logic        skid_last;
    logic        skid_user;
    logic        skid_valid;
    logic        skid_valid_next;

    // The LFSR register holds the next 8 sequence bits, MSB first, so it is the PN byte itself.
    function automatic logic [7:0] pn_advance(input logic [7:0] w);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], r[7] ^ r[4] ^ r[2] ^ r[0]};
        end
        return r;
    endfunction

    assign accept  = s_axis_tvalid && s_axis_tready;
    assign out_pop = m_axis_tvalid && m_axis_tready;
    assign cnt_inc = {1'b0, byte_cnt} + 9'd1;
    assign at_len  = (cnt_inc == 9'(CODEWORD_LEN));

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        lfsr_next     = lfsr;
        en_lat_next   = en_lat;
        en_cur        = (state == S_IDLE) ? derand_en : en_lat;
        word_data     = s_axis_tdata ^ (en_cur ? lfsr : 8'h00);
        word_last     = s_axis_tlast || at_len;
        // Exactly one of "input tlast" and "length reached" marks a bad codeword.
        word_user     = s_axis_tlast ^ at_len;
        if (accept) begin
            if (state == S_IDLE) begin
                en_lat_next = derand_en;
            end
            if (word_last) begin
                state_next    = S_IDLE;
                byte_cnt_next = 8'd0;
                lfsr_next     = PN_SEED;
            end else begin
                state_next    = S_FRAME;
                byte_cnt_next = cnt_inc[7:0];
                lfsr_next     = pn_advance(lfsr);
            end
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_cnt <= 8'd0;
            lfsr     <= PN_SEED;
            en_lat   <= 1'b0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
            lfsr     <= lfsr_next;
            en_lat   <= en_lat_next;
        end
    end

    // Skid entry only fills when the output register is held and a byte arrives.
    assign skid_valid_next = (!m_axis_tvalid || out_pop) ? 1'b0 : (skid_valid || accept);

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            skid_data     <= 8'h00;
            skid_last     <= 1'b0;
            skid_user     <= 1'b0;
            skid_valid    <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            if (!m_axis_tvalid || out_pop) begin
                if (skid_valid) begin
                    m_axis_tdata  <= skid_data;
                    m_axis_tlast  <= skid_last;
                    m_axis_tuser  <= skid_user;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= accept;
                    if (accept) begin
                        m_axis_tdata <= word_data;
                        m_axis_tlast <= word_last;
                        m_axis_tuser <= word_user;
                    end
                end
            end else if (accept) begin
                skid_data <= word_data;
                skid_last <= word_last;
                skid_user <= word_user;
            end
            skid_valid    <= skid_valid_next;
            s_axis_tready <= !skid_valid_next;
        end
    end

`ifdef DERAND_STATS_EN
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'h0000;
            err_cnt   <= 16'h0000;
        end else if (out_pop && m_axis_tlast) begin
            if (frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (m_axis_tuser && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign frame_cnt = 16'h0000;
    assign err_cnt   = 16'h0000;
`endif

endmodule
